uart_cmd_parser: RTL

- Sits directly downstream of the UART receive path and consumes its byte stream (rx_data/rx_valid).
- Parses ASCII command lines into structured commands for the sequencer datapath:
  - write: "W<m>:<hex×NUM_NIB><term>"
  - read: "R<m><term>"
- Mirrors the "R<n>:<hex>" line format the transmit side emits.
- Delivers one command at a time over a valid/ready handshake and flags malformed input.

---
 rtl/uart_cmd_parser_if.sv | 25 ++
 rtl/uart_cmd_parser.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and command/error output bundle for uart_cmd_parser.
// slave = parser side, master = upstream UART / downstream consumer side.
interface uart_cmd_parser_if #(
    parameter int unsigned DP_WIDTH = 16
);
    logic [7:0]          i_rx_data;
    logic                i_rx_valid;
    logic                o_cmd_valid;
    logic                i_cmd_ready;
    logic                o_cmd_wr;
    logic [1:0]          o_cmd_meta;
    logic [DP_WIDTH-1:0] o_cmd_data;
    logic                o_err;
    logic [1:0]          o_err_code;

    modport slave (
        input  i_rx_data, i_rx_valid, i_cmd_ready,
        output o_cmd_valid, o_cmd_wr, o_cmd_meta, o_cmd_data, o_err, o_err_code
    );

    modport master (
        output i_rx_data, i_rx_valid, i_cmd_ready,
        input  o_cmd_valid, o_cmd_wr, o_cmd_meta, o_cmd_data, o_err, o_err_code
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser: "W<m>:<hex x NUM_NIB><CR|LF>" and "R<m><CR|LF>"
// delivered one at a time over valid/ready, with single-cycle error pulses.
module uart_cmd_parser #(
    parameter int unsigned DP_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_parser_if.slave    bus
);
    localparam int unsigned NUM_NIB = DP_WIDTH / 4;
    localparam int unsigned NIB_W   = $clog2(NUM_NIB + 1);

    localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
    localparam logic [1:0] ERR_OVERRUN  = 2'd2;
    localparam logic [1:0] ERR_SHORT    = 2'd3;

    typedef enum logic [2:0] {
        IDLE, META, COLON, DATA, TERM, HOLD, FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [1:0]          meta_q, meta_d;
    logic [DP_WIDTH-1:0] data_q, data_d;
    logic [NIB_W-1:0]    nib_q, nib_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [7:0] rx_b;
    logic       rx_term, rx_space, rx_w, rx_r, rx_colon, rx_meta, rx_hex;
    logic [3:0] rx_nib;
    logic       take_idle;

    always_comb begin
        rx_b     = bus.i_rx_data;
        rx_term  = (rx_b == 8'h0D) || (rx_b == 8'h0A);
        rx_space = (rx_b == 8'h20);
        rx_w     = (rx_b == 8'h57) || (rx_b == 8'h77);
        rx_r     = (rx_b == 8'h52) || (rx_b == 8'h72);
        rx_colon = (rx_b == 8'h3A);
        rx_meta  = (rx_b[7:2] == 6'b001100);
        rx_hex   = 1'b0;
        rx_nib   = '0;
        if (rx_b >= 8'h30 && rx_b <= 8'h39) begin
            rx_hex = 1'b1;
            rx_nib = rx_b[3:0];
        end else if ((rx_b >= 8'h41 && rx_b <= 8'h46) || (rx_b >= 8'h61 && rx_b <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 yields 10
            rx_hex = 1'b1;
            rx_nib = rx_b[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        meta_d     = meta_q;
        data_d     = data_q;
        nib_d      = nib_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        take_idle  = 1'b0;

        if (state_q == HOLD && bus.i_cmd_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end

        if (bus.i_rx_valid) begin
            unique case (state_q)
                IDLE: take_idle = 1'b1;
                HOLD: begin
                    if (bus.i_cmd_ready) begin
                        take_idle = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVERRUN;
                    end
                end
                META: begin
                    if (rx_term) begin
                        err_d = 1'b1; err_code_d = ERR_SHORT; state_d = IDLE;
                    end else if (rx_meta) begin
                        meta_d  = rx_b[1:0];
                        state_d = wr_q ? COLON : TERM;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_BAD_CHAR; state_d = FLUSH;
                    end
                end
                COLON: begin
                    if (rx_term) begin
                        err_d = 1'b1; err_code_d = ERR_SHORT; state_d = IDLE;
                    end else if (rx_colon) begin
                        data_d  = '0;
                        nib_d   = '0;
                        state_d = DATA;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_BAD_CHAR; state_d = FLUSH;
                    end
                end
                DATA: begin
                    if (rx_term) begin
                        err_d = 1'b1; err_code_d = ERR_SHORT; state_d = IDLE;
                    end else if (rx_hex) begin
                        data_d = (data_q << 4) | DP_WIDTH'(rx_nib);
                        nib_d  = nib_q + 1'b1;
                        if (nib_q == NIB_W'(NUM_NIB - 1)) state_d = TERM;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_BAD_CHAR; state_d = FLUSH;
                    end
                end
                TERM: begin
                    if (rx_term) begin
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        err_d = 1'b1; err_code_d = ERR_BAD_CHAR; state_d = FLUSH;
                    end
                end
                FLUSH: if (rx_term) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // A byte landing in the accept cycle of HOLD is parsed as if in IDLE
            if (take_idle) begin
                if (rx_w || rx_r) begin
                    wr_d    = rx_w;
                    data_d  = '0;
                    state_d = META;
                end else if (rx_term || rx_space) begin
                    state_d = IDLE;
                end else begin
                    err_d = 1'b1; err_code_d = ERR_BAD_CHAR; state_d = FLUSH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            meta_q     <= '0;
            data_q     <= '0;
            nib_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            meta_q     <= meta_d;
            data_q     <= data_d;
            nib_q      <= nib_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.o_cmd_valid = valid_q;
    assign bus.o_cmd_wr    = wr_q;
    assign bus.o_cmd_meta  = meta_q;
    assign bus.o_cmd_data  = data_q;
    assign bus.o_err       = err_q;
    assign bus.o_err_code  = err_code_q;
endmodule
